chip8_sound_timer: RTL and testbench

CHIP-8 sound timer (ST) and tone source. The CPU loads ST with `Fx18`. The block decrements ST at 60 Hz from a 60 Hz tick it derives itself, and exports that tick for the delay timer's `clk_60`. While ST is nonzero it streams a square-wave tone to the audio codec interface over a valid/ready sample handshake. It is the consumer/output side of the timer path, sitting between the CPU register file and the audio output.

---
 rtl/chip8_sound_timer_if.sv | 9 +
 rtl/chip8_sound_timer.sv | 136 +++++++++++++
 tb/tb_chip8_sound_timer.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/chip8_sound_timer_if.sv
// Audio sample handshake between the sound timer (master) and the codec (slave).
interface chip8_sound_timer_if;
    logic [15:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;

    modport master (output sample_data, output sample_valid, input sample_ready);
    modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/chip8_sound_timer.sv
// CHIP-8 sound timer with 60 Hz tick source and square-wave tone sample stream.
// Optional CHIP8_ST_READBACK_EN exposes ST on rd_data; otherwise rd_data reads 8'h00.
module chip8_sound_timer #(
    parameter int CLK_HZ            = 50_000_000,
    parameter int TICK_HZ           = 60,
    parameter int SAMPLE_DIV        = 1042,
    parameter int TONE_HALF_SAMPLES = 55,
    parameter int AMPLITUDE         = 8192
) (
    input  logic                       cpu_clk,
    input  logic                       reset_n,
    input  logic                       we,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 rd_data,
    output logic                       active,
    output logic                       tick_60,
    chip8_sound_timer_if.master        snd
);
    // state  | meaning
    // S_IDLE | no sample outstanding, waiting for the next sample strobe
    // S_HOLD | sample offered, held stable until the codec accepts it

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SAMP_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PH_W     = (TONE_HALF_SAMPLES > 1) ? $clog2(TONE_HALF_SAMPLES) : 1;

    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic [SAMP_W-1:0] SAMP_MAX = SAMP_W'(SAMPLE_DIV - 1);
    localparam logic [PH_W-1:0]   PH_MAX   = PH_W'(TONE_HALF_SAMPLES - 1);
    localparam logic [15:0]       AMP_POS  = 16'(AMPLITUDE);
    localparam logic [15:0]       AMP_NEG  = 16'(-AMPLITUDE);

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    logic [TICK_W-1:0] tick_cnt;
    logic [SAMP_W-1:0] samp_cnt;
    logic [7:0]        st;
    logic              strobe;
    logic [PH_W-1:0]   phase;
    logic              polarity;
    logic [15:0]       tone_val;
    logic [15:0]       data_q;
    logic              valid_q;
    state_t            state;

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            tick_60  <= 1'b0;
        end else if (tick_cnt == TICK_MAX) begin
            tick_cnt <= '0;
            tick_60  <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + TICK_W'(1);
            tick_60  <= 1'b0;
        end
    end

    // A write on a tick cycle swallows that tick for ST.
    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= 8'h00;
        end else if (we) begin
            st <= data_in;
        end else if (tick_60 && (st != 8'h00)) begin
            st <= st - 8'h01;
        end
    end

    assign active = (st != 8'h00);

`ifdef CHIP8_ST_READBACK_EN
    assign rd_data = st;
`else
    assign rd_data = 8'h00;
`endif

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            samp_cnt <= '0;
        end else if (strobe) begin
            samp_cnt <= '0;
        end else begin
            samp_cnt <= samp_cnt + SAMP_W'(1);
        end
    end

    assign strobe   = (samp_cnt == SAMP_MAX);
    assign tone_val = active ? (polarity ? AMP_NEG : AMP_POS) : 16'h0000;

    always_ff @(posedge cpu_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            data_q   <= 16'h0000;
            valid_q  <= 1'b0;
            phase    <= '0;
            polarity <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (strobe) begin
                        data_q  <= tone_val;
                        valid_q <= 1'b1;
                        state   <= S_HOLD;
                        if (phase == PH_MAX) begin
                            phase    <= '0;
                            polarity <= ~polarity;
                        end else begin
                            phase <= phase + PH_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (snd.sample_ready) begin
                        valid_q <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
            // Silence pins the tone to phase 0 so each beep starts at +AMPLITUDE.
            if (!active) begin
                phase    <= '0;
                polarity <= 1'b0;
            end
        end
    end

    assign snd.sample_data  = data_q;
    assign snd.sample_valid = valid_q;

endmodule

// File: tb/tb_chip8_sound_timer.sv
// Directed bench for chip8_sound_timer with a 10-cycle tick and 4-cycle sample slot.
module tb_chip8_sound_timer;
    logic       cpu_clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       we      = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] rd_data;
    logic       active;
    logic       tick_60;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    localparam logic [15:0] POS  = 16'h2000;
    localparam logic [15:0] NEG  = 16'hE000;
    localparam logic [15:0] ZERO = 16'h0000;

    chip8_sound_timer_if snd_if ();

    chip8_sound_timer #(
        .CLK_HZ            (600),
        .TICK_HZ           (60),
        .SAMPLE_DIV        (4),
        .TONE_HALF_SAMPLES (2),
        .AMPLITUDE         (8192)
    ) dut (
        .cpu_clk (cpu_clk),
        .reset_n (reset_n),
        .we      (we),
        .data_in (data_in),
        .rd_data (rd_data),
        .active  (active),
        .tick_60 (tick_60),
        .snd     (snd_if)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
        cyc++;
    endtask

    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        reset_n = 1'b0;
        we      = 1'b0;
        @(negedge cpu_clk);
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    task automatic write_st(input logic [7:0] v);
        we      = 1'b1;
        data_in = v;
        step();
        we      = 1'b0;
    endtask

    logic [15:0] exp_s;
    logic [15:0] bp_exp [4];
    logic [7:0]  exp_rd;

    initial begin
        bp_exp = '{POS, NEG, NEG, POS};
`ifdef CHIP8_ST_READBACK_EN
        exp_rd = 8'hA5;
`else
        exp_rd = 8'h00;
`endif
        snd_if.sample_ready = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        check("rst_active", active, 0);
        check("rst_tick", tick_60, 0);
        check("rst_valid", snd_if.sample_valid, 0);
        check("rst_data", snd_if.sample_data, 0);
        check("rst_rd", rd_data, 0);
        check("rst_st", dut.st, 0);

        // tick period and decrement to zero
        do_reset();
        step();
        write_st(8'd3);
        check("wr_active", active, 1);
        check("wr_st", dut.st, 3);
        while (cyc < 45) begin
            step();
            check("tick", tick_60, (cyc % 10 == 0));
            check("active", active, (cyc <= 30));
        end
        check("st_floor", dut.st, 0);

        // tone pattern with ready high
        do_reset();
        snd_if.sample_ready = 1'b1;
        step();
        write_st(8'd5);
        while (cyc < 60) begin
            step();
            check("valid", snd_if.sample_valid, (cyc % 4 == 0));
            if (cyc % 4 == 0) begin
                if (cyc >= 52) exp_s = ZERO;
                else exp_s = ((((cyc / 4) - 1) / 2) % 2 == 0) ? POS : NEG;
                check("tone", snd_if.sample_data, exp_s);
            end
        end

        // write coinciding with tick
        do_reset();
        step();
        write_st(8'd9);
        step_n(8);
        check("tick_at_10", tick_60, 1);
        we      = 1'b1;
        data_in = 8'h07;
        step();
        we      = 1'b0;
        check("wr_wins", dut.st, 7);
        step_n(9);
        check("st_hold7", dut.st, 7);
        step();
        check("st_dec6", dut.st, 6);

        // backpressure
        do_reset();
        snd_if.sample_ready = 1'b0;
        step();
        write_st(8'd5);
        while (cyc < 14) begin
            step();
            if (cyc >= 4) begin
                check("bp_valid", snd_if.sample_valid, 1);
                check("bp_data", snd_if.sample_data, POS);
            end
        end
        snd_if.sample_ready = 1'b1;
        step();
        check("bp_release", snd_if.sample_valid, 0);
        while (cyc < 28) begin
            step();
            if (cyc % 4 == 0) begin
                check("bp_after_v", snd_if.sample_valid, 1);
                check("bp_after_d", snd_if.sample_data, bp_exp[(cyc - 16) / 4]);
            end
        end

        // async reset while holding a sample
        do_reset();
        snd_if.sample_ready = 1'b0;
        step();
        write_st(8'd5);
        step_n(4);
        check("hold_pre", snd_if.sample_valid, 1);
        #2 reset_n = 1'b0;
        #1;
        check("arst_valid", snd_if.sample_valid, 0);
        check("arst_st", dut.st, 0);
        check("arst_active", active, 0);
        check("arst_data", snd_if.sample_data, 0);
        @(negedge cpu_clk);
        reset_n = 1'b1;
        cyc     = 0;
        snd_if.sample_ready = 1'b1;
        step_n(4);
        check("post_rst_v", snd_if.sample_valid, 1);
        check("post_rst_d", snd_if.sample_data, ZERO);

        // readback
        do_reset();
        step();
        write_st(8'hA5);
        check("readback", rd_data, exp_rd);
        check("rb_active", active, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
